alu_core: RTL and testbench

Parameterised, registered arithmetic-logic unit for the UART calculator datapath. It takes two signed operands and a 6-bit operation code in the MIPS-style funct encoding, and produces a registered result with status flags one clock later. It sits between the operand/opcode capture interface, which drives A, B and op, and the UART transmit path, which consumes the result.

---
 rtl/alu_core.sv | 171 +++++++++++++++++
 tb/tb_alu_core.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered MIPS-funct ALU for the UART calculator datapath: one-cycle latency.
// Define ALU_FLAGS_EN to build the zero/carry/overflow/bad-op flag logic.
module alu_core #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_operation,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_bad_op
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(32);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(34);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(36);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(37);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(38);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(39);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(3);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(2);

  localparam int MSB = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] WIDTH_W = NB_DATA[NB_DATA-1:0];

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_nor;
  logic is_sra;
  logic is_srl;

  assign is_add = (i_operation == OP_ADD);
  assign is_sub = (i_operation == OP_SUB);
  assign is_and = (i_operation == OP_AND);
  assign is_or  = (i_operation == OP_OR);
  assign is_xor = (i_operation == OP_XOR);
  assign is_nor = (i_operation == OP_NOR);
  assign is_sra = (i_operation == OP_SRA);
  assign is_srl = (i_operation == OP_SRL);

  logic [NB_DATA-1:0] add_res;
  logic [NB_DATA-1:0] sub_res;
  logic [NB_DATA-1:0] sra_res;
  logic [NB_DATA-1:0] srl_res;
  logic               shift_big;

`ifdef ALU_FLAGS_EN
  logic [NB_DATA:0] add_w;
  logic [NB_DATA:0] sub_w;

  assign add_w   = {1'b0, i_data_a} + {1'b0, i_data_b};
  assign sub_w   = {1'b0, i_data_a} - {1'b0, i_data_b};
  assign add_res = add_w[NB_DATA-1:0];
  assign sub_res = sub_w[NB_DATA-1:0];
`else
  assign add_res = i_data_a + i_data_b;
  assign sub_res = i_data_a - i_data_b;
`endif

  // Shift amounts at or beyond the width saturate instead of wrapping.
  assign shift_big = (i_data_b >= WIDTH_W);
  assign sra_res   = shift_big ? {NB_DATA{i_data_a[MSB]}}
                   : $unsigned($signed(i_data_a) >>> i_data_b);
  assign srl_res   = shift_big ? '0 : (i_data_a >> i_data_b);

  logic [NB_DATA-1:0] result_d;
  logic [NB_DATA-1:0] result_q;
  logic               valid_q;

  always_comb begin
    result_d = '0;
    unique case (1'b1)
      is_add:  result_d = add_res;
      is_sub:  result_d = sub_res;
      is_and:  result_d = i_data_a & i_data_b;
      is_or:   result_d = i_data_a | i_data_b;
      is_xor:  result_d = i_data_a ^ i_data_b;
      is_nor:  result_d = ~(i_data_a | i_data_b);
      is_sra:  result_d = sra_res;
      is_srl:  result_d = srl_res;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= i_valid;
      if (i_valid) begin
        result_q <= result_d;
      end
    end
  end

  assign o_result = result_q;
  assign o_valid  = valid_q;

`ifdef ALU_FLAGS_EN
  logic zero_d;
  logic carry_d;
  logic ovf_d;
  logic bad_d;
  logic zero_q;
  logic carry_q;
  logic ovf_q;
  logic bad_q;

  assign bad_d = ~|{is_add, is_sub, is_and, is_or,
                    is_xor, is_nor, is_sra, is_srl};

  assign zero_d = (result_d == '0);

  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (1'b1)
      is_add: begin
        carry_d = add_w[NB_DATA];
        ovf_d   = (i_data_a[MSB] == i_data_b[MSB])
                & (add_res[MSB] != i_data_a[MSB]);
      end
      is_sub: begin
        carry_d = sub_w[NB_DATA];
        ovf_d   = (i_data_a[MSB] != i_data_b[MSB])
                & (sub_res[MSB] != i_data_a[MSB]);
      end
      default: begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else if (i_valid) begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  assign o_zero     = zero_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_bad_op   = bad_q;
`else
  assign o_zero     = 1'b0;
  assign o_carry    = 1'b0;
  assign o_overflow = 1'b0;
  assign o_bad_op   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (NB_DATA=8) with a reference model.
// Flag expectations follow the ALU_FLAGS_EN build setting.
module tb_alu_core;

`ifdef ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       vld;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic [7:0] res;
  logic       ov;
  logic       z;
  logic       c;
  logic       v;
  logic       bad;

  int n_vec;
  int n_err;

  alu_core #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_valid     (vld),
    .i_data_a    (a),
    .i_data_b    (b),
    .i_operation (op),
    .o_result    (res),
    .o_valid     (ov),
    .o_zero      (z),
    .o_carry     (c),
    .o_overflow  (v),
    .o_bad_op    (bad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       v;
    logic       bad;
  } vec_t;

  vec_t dir_tab [19] = '{
    '{8'd42,  8'd3,   6'd34, 8'd39,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'd1,   8'd2,   6'd34, 8'hFF,  1'b0, 1'b1, 1'b0, 1'b0},
    '{8'd127, 8'd1,   6'd32, 8'h80,  1'b0, 1'b0, 1'b1, 1'b0},
    '{8'h80,  8'd1,   6'd34, 8'h7F,  1'b0, 1'b0, 1'b1, 1'b0},
    '{8'hFF,  8'd1,   6'd32, 8'h00,  1'b1, 1'b1, 1'b0, 1'b0},
    '{8'hF0,  8'h3C,  6'd36, 8'h30,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'hF0,  8'h3C,  6'd37, 8'hFC,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'hF0,  8'h3C,  6'd38, 8'hCC,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'hF0,  8'h3C,  6'd39, 8'h03,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd2,   6'd3,  8'hE0,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd2,   6'd2,  8'h20,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd9,   6'd3,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd9,   6'd2,  8'h00,  1'b1, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd8,   6'd3,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd8,   6'd2,  8'h00,  1'b1, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd7,   6'd3,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h80,  8'd7,   6'd2,  8'h01,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h40,  8'd1,   6'd3,  8'h20,  1'b0, 1'b0, 1'b0, 1'b0},
    '{8'h55,  8'h12,  6'd63, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1}
  };

  // Reference model: plain integer arithmetic on the operation rules.
  task automatic ref_alu(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [5:0] iop, output logic [12:0] e);
    int ua;
    int ub;
    int sa;
    int sb;
    int s;
    logic [7:0] r;
    bit ez;
    bit ec;
    bit ev;
    bit eb;
    ua = ia;
    ub = ib;
    sa = $signed(ia);
    sb = $signed(ib);
    s  = 0;
    ec = 0;
    ev = 0;
    eb = 0;
    r  = 8'h00;
    case (iop)
      6'd32: begin
        s = ua + ub; r = s[7:0]; ec = (s > 255);
        ev = (sa + sb > 127) || (sa + sb < -128);
      end
      6'd34: begin
        s = ua - ub; r = s[7:0]; ec = (ua < ub);
        ev = (sa - sb > 127) || (sa - sb < -128);
      end
      6'd36: r = ia & ib;
      6'd37: r = ia | ib;
      6'd38: r = ia ^ ib;
      6'd39: r = ~(ia | ib);
      6'd2: begin
        s = (ub >= 8) ? 0 : (ua / (1 << ub)); r = s[7:0];
      end
      6'd3: begin
        s = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub); r = s[7:0];
      end
      default: begin r = 8'h00; eb = 1; end
    endcase
    ez = (r == 8'h00);
    e = {r, 1'b1, ez & FL, ec & FL, ev & FL, eb & FL};
  endtask

  task automatic drive(input logic iv, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [5:0] iop);
    vld = iv;
    a   = ia;
    b   = ib;
    op  = iop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom), 6'd32);
      tick();
    end
    got = {res, ov, z, c, v, bad};
    n_vec++;
    if (got !== 13'h0) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=%h", got, 13'h0);
    end
    rst = 1'b0;
    drive(1'b1, 8'd15, 8'd1, 6'd32);
    tick();
    got = {res, ov, z, c, v, bad};
    n_vec++;
    if (got !== {8'd16, 1'b1, 4'b0}) begin
      n_err++;
      $display("FAIL first_add got=%h exp=%h", got, {8'd16, 1'b1, 4'b0});
    end
    drive(1'b0, 8'd99, 8'd7, 6'd34);
    tick();
    got = {res, ov, z, c, v, bad};
    n_vec++;
    if (got !== {8'd16, 1'b0, 4'b0}) begin
      n_err++;
      $display("FAIL first_hold got=%h exp=%h", got, {8'd16, 1'b0, 4'b0});
    end
  endtask

  task automatic test_directed();
    logic [12:0] got;
    logic [12:0] exp;
    logic [12:0] mdl;
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, dir_tab[i].a, dir_tab[i].b, dir_tab[i].op);
      ref_alu(dir_tab[i].a, dir_tab[i].b, dir_tab[i].op, mdl);
      tick();
      got = {res, ov, z, c, v, bad};
      exp = {dir_tab[i].r, 1'b1, dir_tab[i].z & FL, dir_tab[i].c & FL,
             dir_tab[i].v & FL, dir_tab[i].bad & FL};
      n_vec++;
      if (got !== exp || mdl !== exp) begin
        n_err++;
        $display("FAIL directed[%0d] got=%h exp=%h model=%h", i, got, exp, mdl);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 6'd0);
    tick();
  endtask

  task automatic test_hold();
    logic [12:0] got;
    logic [12:0] exp;
    drive(1'b1, 8'hFF, 8'd1, 6'd32);
    ref_alu(8'hFF, 8'd1, 6'd32, exp);
    tick();
    exp[4] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 6'd63);
      tick();
      got = {res, ov, z, c, v, bad};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [12:0] got;
    drive(1'b1, 8'd127, 8'd1, 6'd32);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'd5, 8'd6, 6'd32);
    tick();
    got = {res, ov, z, c, v, bad};
    n_vec++;
    if (got !== 13'h0) begin
      n_err++;
      $display("FAIL reset_wins got=%h exp=%h", got, 13'h0);
    end
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 6'd0);
    tick();
    got = {res, ov, z, c, v, bad};
    n_vec++;
    if (got !== 13'h0) begin
      n_err++;
      $display("FAIL reset_discard got=%h exp=%h", got, 13'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got;
    logic [12:0] exp;
    logic [5:0]  ops [4] = '{6'd32, 6'd34, 6'd38, 6'd3};
    logic [7:0]  ia;
    logic [7:0]  ib;
    for (int i = 0; i < 4; i++) begin
      ia = 8'($urandom);
      ib = 8'($urandom_range(0, 12));
      drive(1'b1, ia, ib, ops[i]);
      ref_alu(ia, ib, ops[i], exp);
      tick();
      got = {res, ov, z, c, v, bad};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    drive(1'b0, 8'd0, 8'd0, 6'd0);
    tick();
  endtask

  task automatic test_random();
    logic [12:0] got;
    logic [12:0] exp;
    logic [12:0] cur;
    logic [5:0]  ops [8] = '{6'd32, 6'd34, 6'd36, 6'd37,
                             6'd38, 6'd39, 6'd3, 6'd2};
    logic [7:0]  ia;
    logic [7:0]  ib;
    logic [5:0]  iop;
    logic        iv;
    cur = {res, 1'b0, z, c, v, bad};
    for (int i = 0; i < 300; i++) begin
      iv  = ($urandom_range(0, 9) < 7);
      ia  = 8'($urandom);
      ib  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10))
                                        : 8'($urandom);
      iop = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                        : ops[$urandom_range(0, 7)];
      drive(iv, ia, ib, iop);
      if (iv) begin
        ref_alu(ia, ib, iop, exp);
        cur = exp;
      end else begin
        cur[4] = 1'b0;
      end
      tick();
      got = {res, ov, z, c, v, bad};
      n_vec++;
      if (got !== cur) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h exp=%h",
                 i, iop, ia, ib, got, cur);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 6'd0);
    test_reset();
    test_directed();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
